config_frame_loader: RTL and testbench

CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

---
 rtl/cfg_loader_pkg.sv | 15 +
 rtl/cfg_shift_reg.sv | 34 +++
 rtl/config_frame_loader.sv | 128 ++++++++++++
 tb/tb_config_frame_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// rtl/cfg_loader_pkg.sv - shared state encoding and parity polarity for the config frame loader
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_COMMIT,
    ST_DONE
  } cfg_state_e;

  // Even parity: data ones plus the parity bit must XOR to this value.
  localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/cfg_shift_reg.sv
// rtl/cfg_shift_reg.sv - right-shifting frame register with running parity
module cfg_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_out,
  output logic             parity_out
);

  logic [WIDTH-1:0] data_q;
  logic             parity_q;

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      parity_q <= 1'b0;
    end else if (clear) begin
      data_q   <= '0;
      parity_q <= 1'b0;
    end else if (shift_en) begin
      data_q   <= {bit_in, data_q[WIDTH-1:1]};
      parity_q <= parity_q ^ bit_in;
    end
  end

  assign data_out   = data_q;
  assign parity_out = parity_q;

endmodule

// File: rtl/config_frame_loader.sv
// rtl/config_frame_loader.sv - serial bitstream to parallel config frames with parity check
module config_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int FRAME_BITS = 16,
  parameter int NUM_FRAMES = 4,
  parameter int FIDX_BITS  = $clog2(NUM_FRAMES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic                  cfg_bit,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [FRAME_BITS-1:0] config_out,
  output logic [NUM_FRAMES-1:0] comb_set,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BCNT_BITS = $clog2(FRAME_BITS + 1);

  cfg_state_e            state_q, state_d;
  logic [FIDX_BITS-1:0]  fidx_q, fidx_d;
  logic [BCNT_BITS-1:0]  bcnt_q, bcnt_d;
  logic [NUM_FRAMES-1:0] comb_set_q, comb_set_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  sr_clear, sr_shift, accept, parity_run;

  cfg_shift_reg #(.WIDTH(FRAME_BITS)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (sr_clear),
    .shift_en  (sr_shift),
    .bit_in    (cfg_bit),
    .data_out  (config_out),
    .parity_out(parity_run)
  );

  assign cfg_ready = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = cfg_valid && cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fidx_q     <= '0;
      bcnt_q     <= '0;
      comb_set_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fidx_q     <= fidx_d;
      bcnt_q     <= bcnt_d;
      comb_set_q <= comb_set_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fidx_d     = fidx_q;
    bcnt_d     = bcnt_q;
    error_d    = error_q;
    comb_set_d = '0;
    done_d     = 1'b0;
    sr_clear   = 1'b0;
    sr_shift   = 1'b0;

    // Abort outranks any accepted bit and any pending strobe.
    if (state_q != ST_IDLE && cfg_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_start && !cfg_abort) begin
            state_d  = ST_SHIFT;
            fidx_d   = '0;
            bcnt_d   = '0;
            error_d  = 1'b0;
            sr_clear = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (accept) begin
            sr_shift = 1'b1;
            if (bcnt_q == BCNT_BITS'(FRAME_BITS - 1)) state_d = ST_PARITY;
            else                                      bcnt_d  = bcnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (accept) begin
            if ((parity_run ^ cfg_bit) == PARITY_EVEN) begin
              state_d    = ST_COMMIT;
              comb_set_d = NUM_FRAMES'(1) << fidx_q;
            end else begin
              state_d = ST_IDLE;
              error_d = 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          sr_clear = 1'b1;
          bcnt_d   = '0;
          if (fidx_q == FIDX_BITS'(NUM_FRAMES - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            fidx_d  = fidx_q + 1'b1;
            state_d = ST_SHIFT;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign comb_set = comb_set_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// tb/tb_config_frame_loader.sv - directed self-checking bench for config_frame_loader
module tb_config_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start, cfg_abort, cfg_bit, cfg_valid;
  logic        cfg_ready, busy, done, error;
  logic [15:0] config_out;
  logic [3:0]  comb_set;

  int errors = 0;
  int checks = 0;

  logic [15:0] frames [4] = '{16'hA5C3, 16'h0001, 16'hFFFF, 16'h1234};
  logic        pars   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic        mon_clr = 1'b0;
  logic [3:0]  cs_log [$];
  logic [15:0] data_log [$];
  int          done_cnt, acc_cnt, multi_cnt;

  config_frame_loader #(.FRAME_BITS(16), .NUM_FRAMES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_abort (cfg_abort),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .config_out(config_out),
    .comb_set  (comb_set),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_clr) begin
      cs_log.delete();
      data_log.delete();
      done_cnt  = 0;
      acc_cnt   = 0;
      multi_cnt = 0;
    end else begin
      if (comb_set != 4'b0) begin
        cs_log.push_back(comb_set);
        data_log.push_back(config_out);
        if ((comb_set & (comb_set - 4'd1)) != 4'b0) multi_cnt++;
      end
      if (done === 1'b1) done_cnt++;
      if (cfg_valid === 1'b1 && cfg_ready === 1'b1) acc_cnt++;
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pass();
    cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    while (!acc) begin
      cfg_bit   = b;
      cfg_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      acc       = cfg_valid && cfg_ready;
      @(posedge clk); #1;
      guard++;
      if (!acc && guard > 200) begin
        checks++; errors++;
        $display("FAIL send_bit_timeout: cfg_ready=%0b after %0d cycles, required 1", cfg_ready, guard);
        acc = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] d, input logic p, input bit gaps);
    for (int i = 0; i < 16; i++) send_bit(d[i], gaps);
    send_bit(p, gaps);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
    #1 rst_n = 1'b0;
    wait_cycles(2);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (cfg_ready !== 1'b0)  begin errors++; $display("FAIL reset_ready: got %0b want 0", cfg_ready); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (error !== 1'b0)      begin errors++; $display("FAIL reset_error: got %0b want 0", error); end
    checks++; if (comb_set !== 4'b0)   begin errors++; $display("FAIL reset_comb_set: got %b want 0000", comb_set); end
    checks++; if (config_out !== 16'h0) begin errors++; $display("FAIL reset_config_out: got %h want 0000", config_out); end
    rst_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_full_pass(input bit gaps, input string tag);
    clear_mon();
    start_pass();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL %s_error_cleared: got %0b want 0", tag, error); end
    for (int f = 0; f < 4; f++) send_frame(frames[f], pars[f], gaps);
    cfg_valid = 1'b0;
    wait_cycles(4);
    checks++;
    if (cs_log.size() != 4) begin
      errors++; $display("FAIL %s_pulse_count: got %0d want 4", tag, cs_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (cs_log[i] !== (4'b0001 << i)) begin errors++; $display("FAIL %s_comb_set%0d: got %b want %b", tag, i, cs_log[i], 4'b0001 << i); end
        checks++; if (data_log[i] !== frames[i]) begin errors++; $display("FAIL %s_config_out%0d: got %h want %h", tag, i, data_log[i], frames[i]); end
      end
    end
    checks++; if (acc_cnt != 68)  begin errors++; $display("FAIL %s_accepts: got %0d want 68", tag, acc_cnt); end
    checks++; if (done_cnt != 1)  begin errors++; $display("FAIL %s_done_cycles: got %0d want 1", tag, done_cnt); end
    checks++; if (multi_cnt != 0) begin errors++; $display("FAIL %s_onehot: got %0d multi-bit cycles want 0", tag, multi_cnt); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL %s_error: got %0b want 0", tag, error); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL %s_busy_end: got %0b want 0", tag, busy); end
  endtask

  task automatic test_parity_error();
    clear_mon();
    start_pass();
    send_frame(frames[0], pars[0], 1'b0);
    send_frame(16'h0001, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL perr_error: got %0b want 1", error); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL perr_busy: got %0b want 0", busy); end
    wait_cycles(5);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL perr_error_sticky: got %0b want 1", error); end
    checks++; if (cs_log.size() != 1 || cs_log[0] !== 4'b0001) begin
      errors++; $display("FAIL perr_pulses: got %0d pulses want exactly one 0001", cs_log.size());
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL perr_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_abort();
    clear_mon();
    start_pass();
    send_frame(frames[0], pars[0], 1'b0);
    send_frame(frames[1], pars[1], 1'b0);
    for (int i = 0; i < 7; i++) send_bit(frames[2][i], 1'b0);
    cfg_bit = frames[2][7]; cfg_valid = 1'b1; cfg_abort = 1'b1;
    @(posedge clk); #1 cfg_abort = 1'b0; cfg_valid = 1'b0;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %0b want 0", cfg_ready); end
    wait_cycles(5);
    checks++; if (cs_log.size() != 2 || cs_log[0] !== 4'b0001 || cs_log[1] !== 4'b0010) begin
      errors++; $display("FAIL abort_pulses: got %0d pulses want 0001,0010", cs_log.size());
    end
    checks++; if (done_cnt != 0)  begin errors++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL abort_error: got %0b want 0", error); end
    cfg_start = 1'b1; cfg_abort = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0; cfg_abort = 1'b0;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL start_abort_idle: got busy %0b want 0", busy); end
    test_full_pass(1'b0, "after_abort");
  endtask

  task automatic test_reset_mid();
    clear_mon();
    start_pass();
    send_frame(frames[0], pars[0], 1'b0);
    for (int i = 0; i < 5; i++) send_bit(frames[1][i], 1'b0);
    cfg_start = 1'b1;
    send_bit(frames[1][5], 1'b0);
    cfg_start = 1'b0;
    for (int i = 6; i < 16; i++) send_bit(frames[1][i], 1'b0);
    send_bit(pars[1], 1'b0);
    cfg_valid = 1'b0;
    checks++; if (comb_set !== 4'b0010) begin errors++; $display("FAIL rmid_commit_idx: got %b want 0010", comb_set); end
    checks++; if (config_out !== frames[1]) begin errors++; $display("FAIL rmid_commit_data: got %h want %h", config_out, frames[1]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({comb_set, busy, done, error, cfg_ready} !== 8'b0) begin
      errors++; $display("FAIL rmid_async_outputs: got %b want 00000000", {comb_set, busy, done, error, cfg_ready});
    end
    checks++; if (config_out !== 16'h0) begin errors++; $display("FAIL rmid_async_data: got %h want 0000", config_out); end
    #2 rst_n = 1'b1;
    wait_cycles(5);
    checks++; if (cs_log.size() != 1 || cs_log[0] !== 4'b0001) begin
      errors++; $display("FAIL rmid_pulses: got %0d pulses want only 0001", cs_log.size());
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_full_pass(1'b0, "full");
    test_parity_error();
    test_full_pass(1'b1, "gaps");
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
